fifo_rd_stream: RTL and testbench

Read-domain consumer for the team's asynchronous FIFO, running on `r_clk`. Drains the FIFO via `pop`/`r_empty`/`r_data` and presents the words on a valid/ready stream with packet framing (`m_last` every `PKT_LEN` words). Hides the FIFO RAM's one-cycle read latency behind a 2-entry output buffer, so a continuously ready sink gets one word per cycle.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/rd_skid_buf.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 76 +++++++
 tb/tb_fifo_rd_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and helpers for the FIFO read-side streamer
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = 2;

  // Packet beat counter width; a 1-word packet still needs a 1-bit vector.
  function automatic int beat_width(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 2-entry register buffer absorbing the FIFO RAM read latency
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output logic [BUF_CNT_W-1:0]  cnt
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  // slot0 is always the head; a read shifts slot1 forward.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10: begin
          if (cnt != BUF_CNT_W'(BUF_DEPTH)) begin
            if (cnt == '0) slot0 <= wr_data;
            else           slot1 <= wr_data;
            cnt <= cnt + BUF_CNT_W'(1);
          end
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - BUF_CNT_W'(1);
        end
        2'b11: begin
          if (cnt == BUF_CNT_W'(1)) begin
            slot0 <= wr_data;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the async FIFO read port onto a framed valid/ready stream
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  en,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  pop,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int BEAT_W = beat_width(PKT_LEN);

  logic                 inflight;
  logic                 take;
  logic [BUF_CNT_W-1:0] cnt;
  logic [BUF_CNT_W:0]   credit;

  assign m_valid = (cnt != '0);
  assign take    = m_valid && m_ready;

  // Words already owed to the buffer after this cycle; take implies cnt >= 1, so no underflow.
  assign credit = {1'b0, cnt} + {{BUF_CNT_W{1'b0}}, inflight} - {{BUF_CNT_W{1'b0}}, take};
  assign pop    = r_rst_n && en && !r_empty && (credit < (BUF_CNT_W+1)'(BUF_DEPTH));

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= pop;
      if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .r_clk  (r_clk),
    .r_rst_n(r_rst_n),
    .wr_en  (inflight),
    .wr_data(r_data),
    .rd_en  (take),
    .head   (m_data),
    .cnt    (cnt)
  );

  generate
    if (PKT_LEN == 1) begin : g_single
      assign m_last = 1'b1;
    end else begin : g_multi
      logic [BEAT_W-1:0] beat;

      always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
          beat <= '0;
        end else if (take) begin
          beat <= (beat == BEAT_W'(PKT_LEN-1)) ? '0 : beat + BEAT_W'(1);
        end
      end

      assign m_last = (beat == BEAT_W'(PKT_LEN-1));
    end
  endgenerate

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream with a queue-based FIFO model
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PL = 4;
  localparam int CW = 4;

  logic          r_clk   = 1'b0;
  logic          r_rst_n = 1'b0;
  logic          en      = 1'b0;
  logic          r_empty = 1'b1;
  logic [DW-1:0] r_data  = '0;
  logic          m_ready = 1'b0;
  logic          pop;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [CW-1:0] rd_count;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] fq[$];     // words sitting in the FIFO
  logic [DW-1:0] sb[$];     // words popped but not yet delivered
  logic [DW-1:0] got_w[$];
  logic          got_l[$];
  logic [DW-1:0] exp_w[$];
  logic [DW-1:0] tb_w;
  int            popped     = 0;
  int            exp_beat   = 0;
  int            pops_seen  = 0;
  logic          hold_prev  = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  typedef struct {
    logic          pop;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;
  vec_t tbl[11];

  always #5 r_clk = ~r_clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .PKT_LEN   (PL),
    .CNT_WIDTH (CW)
  ) dut (
    .r_clk   (r_clk),
    .r_rst_n (r_rst_n),
    .en      (en),
    .r_empty (r_empty),
    .r_data  (r_data),
    .pop     (pop),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .rd_count(rd_count)
  );

  // FIFO read port: data appears the cycle after a pop and is held until the next pop.
  always @(posedge r_clk) begin
    if (pop && fq.size() > 0) begin
      tb_w = fq.pop_front();
      r_data <= tb_w;
      sb.push_back(tb_w);
      popped++;
    end
    r_empty <= (fq.size() == 0);
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic cyc(input logic rdy, input logic e);
    @(negedge r_clk);
    m_ready = rdy;
    en      = e;
    #1;
    chk("pop_legal", pop & (r_empty | ~en), 0);
    chk("occupancy", longint'(sb.size() <= 2), 1);
    chk("rd_count", rd_count, popped % (1 << CW));
    if (hold_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_data);
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) chk("spurious_word", 1, 0);
      else chk("word_order", m_data, sb.pop_front());
      chk("m_last", m_last, longint'(exp_beat == PL-1));
      exp_beat = (exp_beat + 1) % PL;
      got_w.push_back(m_data);
      got_l.push_back(m_last);
    end
    if (pop) pops_seen++;
    hold_prev = m_valid && !m_ready;
    prev_data = m_data;
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    #2 r_rst_n = 1'b0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_count", rd_count, 0);
    sb.delete();
    popped    = 0;
    exp_beat  = 0;
    hold_prev = 1'b0;
    @(negedge r_clk);
    r_rst_n = 1'b1;
  endtask

  task automatic drain(input int want);
    int guard = 0;
    while (got_w.size() < want && guard < 100) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    chk("drain_count", got_w.size(), want);
  endtask

  task automatic chk_words(input string name);
    int bad = 0;
    for (int i = 0; i < exp_w.size(); i++)
      if (i >= got_w.size() || got_w[i] != exp_w[i]) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    int k0;
    int bad;
    int guard;
    int n_push;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'h10, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h12, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h13, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'h14, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h15, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h16, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h17, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0};

    do_reset();

    // Continuous stream with latency and throughput checked cycle by cycle.
    got_w.delete();
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));
    k0 = -1;
    for (int i = 0; i < 5 && k0 < 0; i++) begin
      cyc(1'b1, 1'b1);
      if (!r_empty) k0 = i;
    end
    chk("stream_empty_fall", k0, 0);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) cyc(1'b1, 1'b1);
      chk("stream_pop", pop, tbl[k].pop);
      chk("stream_valid", m_valid, tbl[k].valid);
      if (tbl[k].valid) begin
        chk("stream_data", m_data, tbl[k].data);
        chk("stream_last", m_last, tbl[k].last);
      end
    end
    chk("stream_rd_count", rd_count, 8);
    chk("stream_words", got_w.size(), 8);

    // Backpressure: 10 stalled cycles, then drain.
    got_w.delete();
    exp_w.delete();
    for (int i = 0; i < 6; i++) begin
      fq.push_back(8'(8'h10 + i));
      exp_w.push_back(8'(8'h10 + i));
    end
    pops_seen = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      if (m_valid && m_data != 8'h10) bad++;
    end
    chk("bp_pops", pops_seen, 2);
    chk("bp_head_hold", bad, 0);
    chk("bp_valid_held", m_valid, 1);
    drain(6);
    chk_words("bp_words");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    chk("bp_no_extra", got_w.size(), 6);

    // Underrun mid-packet: framing must resume where it stopped.
    do_reset();
    got_w.delete();
    got_l.delete();
    fq.push_back(8'h30);
    fq.push_back(8'h31);
    drain(2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1);
      if (m_valid) bad++;
    end
    chk("ur_gap_idle", bad, 0);
    fq.push_back(8'h32);
    fq.push_back(8'h33);
    drain(4);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i < got_l.size() && got_l[i] != (i == 3)) bad++;
    chk("ur_last_pattern", bad, 0);

    // Enable drop right after a pop with one word buffered and one in flight.
    do_reset();
    fq.push_back(8'h40);
    fq.push_back(8'h41);
    fq.push_back(8'h42);
    pops_seen = 0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("en_pre_pops", pops_seen, 2);
    pops_seen = 0;
    got_w.delete();
    exp_w.delete();
    exp_w.push_back(8'h40);
    exp_w.push_back(8'h41);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
    chk("en_drain_words", got_w.size(), 2);
    chk_words("en_drain_data");
    chk("en_no_pop", pops_seen, 0);
    chk("en_rd_count", rd_count, 2);
    drain(3);
    chk("en_resume_word", got_w[got_w.size()-1], 8'h42);

    // Reset with a word in flight and one buffered.
    do_reset();
    fq.push_back(8'h50);
    fq.push_back(8'h51);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    do_reset();
    got_w.delete();
    got_l.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    chk("rst_no_ghost", got_w.size(), 0);
    exp_w.delete();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(8'(8'h60 + i));
      exp_w.push_back(8'(8'h60 + i));
    end
    drain(4);
    chk_words("rst_new_words");
    chk("rst_new_last", (got_l.size() == 4) ? {got_l[0], got_l[1], got_l[2], got_l[3]} : 4'hf, 4'b0001);

    // Counter wrap with random sink readiness.
    do_reset();
    got_w.delete();
    got_l.delete();
    exp_w.delete();
    for (int i = 0; i < 17; i++) begin
      tb_w = 8'($urandom);
      fq.push_back(tb_w);
      exp_w.push_back(tb_w);
    end
    guard = 0;
    while (got_w.size() < 17 && guard < 300) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'b1);
      guard++;
    end
    chk("wrap_words", got_w.size(), 17);
    chk_words("wrap_data");
    chk("wrap_rd_count", rd_count, 1);
    bad = 0;
    for (int i = 0; i < got_l.size(); i++)
      if (got_l[i] != (i % 4 == 3)) bad++;
    chk("wrap_last_every4", bad, 0);

    // Random traffic, enable and readiness against the scoreboard.
    do_reset();
    got_w.delete();
    exp_w.delete();
    n_push = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        tb_w = 8'($urandom);
        fq.push_back(tb_w);
        exp_w.push_back(tb_w);
        n_push++;
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0));
    end
    guard = 0;
    while (got_w.size() < n_push && guard < 2000) begin
      cyc(1'b1, 1'b1);
      guard++;
    end
    chk("rand_all_delivered", got_w.size(), n_push);
    chk_words("rand_data");
    chk("rand_rd_count", rd_count, n_push % (1 << CW));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
